// File: rtl/id_operand_if.sv
// ID operand stage bus: decode inputs, register file port,
// forwarding sources, pipeline control and ID/EX outputs.
interface id_operand_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              id_writes_reg;
  logic              id_is_load;

  logic [ADDR_W-1:0] rf_addr1;
  logic [ADDR_W-1:0] rf_addr2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;

  logic              ex_fwd_valid;
  logic [ADDR_W-1:0] ex_fwd_rd;
  logic              ex_fwd_we;
  logic              ex_fwd_is_load;
  logic [DATA_W-1:0] ex_fwd_data;

  logic              mem_fwd_valid;
  logic [ADDR_W-1:0] mem_fwd_rd;
  logic              mem_fwd_we;
  logic [DATA_W-1:0] mem_fwd_data;

  logic              wb_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              flush;
  logic              ex_hold;
  logic              stall;

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_writes_reg;
  logic              ex_is_load;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_rd, id_writes_reg, id_is_load,
    input  rf_addr1, rf_addr2,
    output rf_data1, rf_data2,
    output ex_fwd_valid, ex_fwd_rd, ex_fwd_we,
    output ex_fwd_is_load, ex_fwd_data,
    output mem_fwd_valid, mem_fwd_rd, mem_fwd_we, mem_fwd_data,
    output wb_write, wb_addr, wb_data,
    output flush, ex_hold,
    input  stall, opnd_a, opnd_b, ex_valid, ex_rd,
    input  ex_writes_reg, ex_is_load, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_rd, id_writes_reg, id_is_load,
    output rf_addr1, rf_addr2,
    input  rf_data1, rf_data2,
    input  ex_fwd_valid, ex_fwd_rd, ex_fwd_we,
    input  ex_fwd_is_load, ex_fwd_data,
    input  mem_fwd_valid, mem_fwd_rd, mem_fwd_we, mem_fwd_data,
    input  wb_write, wb_addr, wb_data,
    input  flush, ex_hold,
    output stall, opnd_a, opnd_b, ex_valid, ex_rd,
    output ex_writes_reg, ex_is_load, stall_count
  );
endinterface

// File: rtl/id_operand_stage.sv
// Operand resolution with EX/MEM/WB forwarding, load-use
// detection and the ID/EX pipeline register.
module id_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input logic         clk,
  input logic         reset_n,
  id_operand_if.slave bus
);

  logic              w_ex_ok;
  logic              w_mem_ok;
  logic              w_ex_a, w_mem_a, w_wb_a;
  logic              w_ex_b, w_mem_b, w_wb_b;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;
  logic              w_load_use;

  logic [DATA_W-1:0] r_opnd_a;
  logic [DATA_W-1:0] r_opnd_b;
  logic              r_valid;
  logic [ADDR_W-1:0] r_rd;
  logic              r_wr;
  logic              r_ld;
  logic [15:0]       r_cnt;

  assign bus.rf_addr1 = bus.id_rs;
  assign bus.rf_addr2 = bus.id_rt;

  // A load in EX has no data yet; it is handled by load_use
  assign w_ex_ok  = bus.ex_fwd_valid & bus.ex_fwd_we
                  & ~bus.ex_fwd_is_load;
  assign w_mem_ok = bus.mem_fwd_valid & bus.mem_fwd_we;

  assign w_ex_a  = w_ex_ok & (bus.ex_fwd_rd == bus.id_rs);
  assign w_mem_a = ~w_ex_a & w_mem_ok
                 & (bus.mem_fwd_rd == bus.id_rs);
  assign w_wb_a  = ~w_ex_a & ~w_mem_a & bus.wb_write
                 & (bus.wb_addr == bus.id_rs);

  assign w_ex_b  = w_ex_ok & (bus.ex_fwd_rd == bus.id_rt);
  assign w_mem_b = ~w_ex_b & w_mem_ok
                 & (bus.mem_fwd_rd == bus.id_rt);
  assign w_wb_b  = ~w_ex_b & ~w_mem_b & bus.wb_write
                 & (bus.wb_addr == bus.id_rt);

  always_comb begin
    w_opnd_a = bus.rf_data1;
    unique case (1'b1)
      w_ex_a:  w_opnd_a = bus.ex_fwd_data;
      w_mem_a: w_opnd_a = bus.mem_fwd_data;
      w_wb_a:  w_opnd_a = bus.wb_data;
      default: w_opnd_a = bus.rf_data1;
    endcase
  end

  always_comb begin
    w_opnd_b = bus.rf_data2;
    unique case (1'b1)
      w_ex_b:  w_opnd_b = bus.ex_fwd_data;
      w_mem_b: w_opnd_b = bus.mem_fwd_data;
      w_wb_b:  w_opnd_b = bus.wb_data;
      default: w_opnd_b = bus.rf_data2;
    endcase
  end

  assign w_load_use = bus.id_valid & bus.ex_fwd_valid
    & bus.ex_fwd_is_load & bus.ex_fwd_we
    & ((bus.id_uses_rs & (bus.ex_fwd_rd == bus.id_rs))
     | (bus.id_uses_rt & (bus.ex_fwd_rd == bus.id_rt)));

  assign bus.stall = ~bus.flush & (w_load_use | bus.ex_hold);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opnd_a <= '0;
      r_opnd_b <= '0;
      r_valid  <= 1'b0;
      r_rd     <= '0;
      r_wr     <= 1'b0;
      r_ld     <= 1'b0;
      r_cnt    <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_ld    <= 1'b0;
    end else if (bus.ex_hold) begin
      r_valid <= r_valid;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_ld    <= 1'b0;
      if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end else begin
      r_opnd_a <= w_opnd_a;
      r_opnd_b <= w_opnd_b;
      r_valid  <= bus.id_valid;
      r_rd     <= bus.id_rd;
      r_wr     <= bus.id_writes_reg & bus.id_valid;
      r_ld     <= bus.id_is_load & bus.id_valid;
    end
  end

  assign bus.opnd_a        = r_opnd_a;
  assign bus.opnd_b        = r_opnd_b;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_writes_reg = r_wr;
  assign bus.ex_is_load    = r_ld;
  assign bus.stall_count   = r_cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized and directed bench for id_operand_stage against
// an in-flight-producer reference model.
module tb_id_operand_stage;

  logic clk;
  logic reset_n;
  int   errs;
  int   checks;

  logic [15:0] regs [4];
  logic [15:0] m_a, m_b, m_cnt;
  logic        m_valid, m_wr, m_ld;
  logic [1:0]  m_rd;

  id_operand_if #(.DATA_W(16), .ADDR_W(2)) bus ();

  id_operand_stage #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.rf_data1 = regs[bus.rf_addr1];
  assign bus.rf_data2 = regs[bus.rf_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_rd = 0;
    bus.id_writes_reg = 0; bus.id_is_load = 0;
    bus.ex_fwd_valid = 0; bus.ex_fwd_rd = 0; bus.ex_fwd_we = 0;
    bus.ex_fwd_is_load = 0; bus.ex_fwd_data = 0;
    bus.mem_fwd_valid = 0; bus.mem_fwd_rd = 0;
    bus.mem_fwd_we = 0; bus.mem_fwd_data = 0;
    bus.wb_write = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.flush = 0; bus.ex_hold = 0;
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_cnt = 0; m_valid = 0;
    m_wr = 0; m_ld = 0; m_rd = 0;
  endtask

  // Newest in-flight producer of register r wins, else the
  // architectural value; loads still in EX cannot supply data.
  function automatic logic [15:0] resolve(input logic [1:0] r);
    bit          ok [3];
    logic [1:0]  rd [3];
    logic [15:0] d  [3];
    ok[0] = bus.ex_fwd_valid && bus.ex_fwd_we && !bus.ex_fwd_is_load;
    rd[0] = bus.ex_fwd_rd;  d[0] = bus.ex_fwd_data;
    ok[1] = bus.mem_fwd_valid && bus.mem_fwd_we;
    rd[1] = bus.mem_fwd_rd; d[1] = bus.mem_fwd_data;
    ok[2] = bus.wb_write;
    rd[2] = bus.wb_addr;    d[2] = bus.wb_data;
    for (int i = 0; i < 3; i++)
      if (ok[i] && rd[i] == r) return d[i];
    return regs[r];
  endfunction

  function automatic bit hazard();
    bit older_load;
    bit reads;
    older_load = bus.ex_fwd_valid && bus.ex_fwd_we
              && bus.ex_fwd_is_load;
    reads = (bus.id_uses_rs && bus.id_rs == bus.ex_fwd_rd)
         || (bus.id_uses_rt && bus.id_rt == bus.ex_fwd_rd);
    return bus.id_valid && older_load && reads;
  endfunction

  task automatic check_regs();
    chk("opnd_a", bus.opnd_a, m_a);
    chk("opnd_b", bus.opnd_b, m_b);
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_rd", bus.ex_rd, m_rd);
    chk("ex_writes_reg", bus.ex_writes_reg, m_wr);
    chk("ex_is_load", bus.ex_is_load, m_ld);
    chk("stall_count", bus.stall_count, m_cnt);
  endtask

  task automatic cycle();
    bit          lu;
    logic [15:0] a, b;
    bit          wbw;
    logic [1:0]  wba;
    logic [15:0] wbd;
    #1;
    lu = hazard();
    chk("stall", bus.stall, !bus.flush && (lu || bus.ex_hold));
    chk("rf_addr1", bus.rf_addr1, bus.id_rs);
    chk("rf_addr2", bus.rf_addr2, bus.id_rt);
    @(posedge clk);
    a = resolve(bus.id_rs);
    b = resolve(bus.id_rt);
    wbw = bus.wb_write; wba = bus.wb_addr; wbd = bus.wb_data;
    if (bus.flush) begin
      m_valid = 0; m_wr = 0; m_ld = 0;
    end else if (bus.ex_hold) begin
      m_valid = m_valid;
    end else if (lu) begin
      m_valid = 0; m_wr = 0; m_ld = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end else begin
      m_a = a; m_b = b;
      m_valid = bus.id_valid;
      m_rd = bus.id_rd;
      m_wr = bus.id_writes_reg && bus.id_valid;
      m_ld = bus.id_is_load && bus.id_valid;
    end
    @(negedge clk);
    if (wbw) regs[wba] = wbd;
    check_regs();
  endtask

  task automatic rand_inputs();
    bus.id_valid = ($urandom_range(0, 7) != 0);
    bus.id_rs = 2'($urandom); bus.id_rt = 2'($urandom);
    bus.id_uses_rs = 1'($urandom); bus.id_uses_rt = 1'($urandom);
    bus.id_rd = 2'($urandom);
    bus.id_writes_reg = 1'($urandom);
    bus.id_is_load = 1'($urandom);
    bus.ex_fwd_valid = 1'($urandom); bus.ex_fwd_rd = 2'($urandom);
    bus.ex_fwd_we = 1'($urandom);
    bus.ex_fwd_is_load = 1'($urandom);
    bus.ex_fwd_data = 16'($urandom);
    bus.mem_fwd_valid = 1'($urandom);
    bus.mem_fwd_rd = 2'($urandom);
    bus.mem_fwd_we = 1'($urandom);
    bus.mem_fwd_data = 16'($urandom);
    bus.wb_write = 1'($urandom); bus.wb_addr = 2'($urandom);
    bus.wb_data = 16'($urandom);
    bus.flush = ($urandom_range(0, 7) == 0);
    bus.ex_hold = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    errs = 0; checks = 0;
    for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
    idle();
    model_reset();
    reset_n = 0;
    #1;
    check_regs();
    chk("reset_stall", bus.stall, 0);
    @(negedge clk);
    reset_n = 1;

    // Forwarding priority EX > MEM > WB > register file
    bus.id_valid = 1; bus.id_rs = 1; bus.id_uses_rs = 1;
    bus.id_rd = 3; bus.id_writes_reg = 1;
    bus.ex_fwd_valid = 1; bus.ex_fwd_we = 1;
    bus.ex_fwd_rd = 1; bus.ex_fwd_data = 16'h1111;
    bus.mem_fwd_valid = 1; bus.mem_fwd_we = 1;
    bus.mem_fwd_rd = 1; bus.mem_fwd_data = 16'h2222;
    bus.wb_write = 1; bus.wb_addr = 1; bus.wb_data = 16'h3333;
    cycle();
    chk("prio_ex", bus.opnd_a, 16'h1111);
    bus.ex_fwd_rd = 2;
    cycle();
    chk("prio_mem", bus.opnd_a, 16'h2222);
    bus.mem_fwd_valid = 0;
    cycle();
    chk("prio_wb", bus.opnd_a, 16'h3333);
    bus.wb_write = 0;
    regs[1] = 16'h4444;
    cycle();
    chk("prio_rf", bus.opnd_a, 16'h4444);

    // Load-use: one bubble, then MEM forwards the load data
    idle();
    bus.ex_fwd_valid = 1; bus.ex_fwd_we = 1;
    bus.ex_fwd_is_load = 1; bus.ex_fwd_rd = 2;
    bus.id_valid = 1; bus.id_rt = 2; bus.id_uses_rt = 1;
    #1 chk("lu_stall", bus.stall, 1);
    cycle();
    chk("lu_bubble", bus.ex_valid, 0);
    chk("lu_count", bus.stall_count, 1);
    bus.ex_fwd_valid = 0;
    bus.mem_fwd_valid = 1; bus.mem_fwd_we = 1;
    bus.mem_fwd_rd = 2; bus.mem_fwd_data = 16'hBEEF;
    #1 chk("lu_nostall", bus.stall, 0);
    cycle();
    chk("lu_fwd", bus.opnd_b, 16'hBEEF);
    chk("lu_valid", bus.ex_valid, 1);

    // Unused source never stalls
    bus.mem_fwd_valid = 0;
    bus.ex_fwd_valid = 1; bus.id_uses_rt = 0;
    #1 chk("unused_stall", bus.stall, 0);
    cycle();
    chk("unused_valid", bus.ex_valid, 1);
    chk("unused_count", bus.stall_count, 1);

    // Flush beats load-use and hold
    bus.id_uses_rt = 1; bus.flush = 1;
    #1 chk("flush_stall", bus.stall, 0);
    cycle();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_count", bus.stall_count, 1);
    bus.flush = 0; bus.ex_fwd_valid = 0;
    cycle();
    chk("refill_valid", bus.ex_valid, 1);
    bus.flush = 1; bus.ex_hold = 1;
    #1 chk("fh_stall", bus.stall, 0);
    cycle();
    chk("fh_valid", bus.ex_valid, 0);

    // Hold freezes the ID/EX register
    idle();
    bus.id_valid = 1; bus.id_rs = 0; bus.id_uses_rs = 1;
    bus.ex_fwd_valid = 1; bus.ex_fwd_we = 1;
    bus.ex_fwd_rd = 0; bus.ex_fwd_data = 16'h00A5;
    cycle();
    chk("hold_load", bus.opnd_a, 16'h00A5);
    bus.ex_hold = 1; bus.ex_fwd_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", bus.stall, 1);
      cycle();
      chk("hold_opnd", bus.opnd_a, 16'h00A5);
      chk("hold_valid", bus.ex_valid, 1);
    end
    bus.ex_hold = 0; bus.ex_fwd_data = 16'h5A5A;
    cycle();
    chk("hold_release", bus.opnd_a, 16'h5A5A);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // Asynchronous reset between edges
    idle();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_regs();
    chk("mid_reset_stall", bus.stall, 0);
    @(negedge clk);
    reset_n = 1;

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand stage of the pipelined 16-bit CPU.
- Drives the register file read addresses and takes its combinational read data.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and detects load-use hazards.
- Registers the resolved operands plus control into the ID/EX pipeline register, with stall, bubble and flush handling.

Parameters:
- DATA_W, 16, operand/result width.
- ADDR_W, 2, register address width (2^ADDR_W architectural registers).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID slot holds a real instruction.
- id_rs, id_rt  input  ADDR_W  source register addresses.
- id_uses_rs, id_uses_rt  input  1  the corresponding source is actually read.
- id_rd  input  ADDR_W  destination register.
- id_writes_reg  input  1  instruction writes id_rd.
- id_is_load  input  1  instruction is a load.
- rf_addr1, rf_addr2  output  ADDR_W  register file read addresses; combinational copies of id_rs and id_rt.
- rf_data1, rf_data2  input  DATA_W  register file read data.
- ex_fwd_valid, ex_fwd_rd, ex_fwd_we, ex_fwd_is_load, ex_fwd_data  input  1/ADDR_W/1/1/DATA_W  state of the instruction currently in EX.
- mem_fwd_valid, mem_fwd_rd, mem_fwd_we, mem_fwd_data  input  1/ADDR_W/1/DATA_W  state of the instruction in MEM; data is final, including load data.
- wb_write, wb_addr, wb_data  input  1/ADDR_W/DATA_W  register file write port this cycle.
- flush  input  1  squash the ID instruction (taken branch/jump).
- ex_hold  input  1  downstream stall; freeze the ID/EX register.
- stall  output  1  freeze PC and IF/ID; combinational.
- opnd_a, opnd_b  output  DATA_W  registered resolved operands.
- ex_valid, ex_rd, ex_writes_reg, ex_is_load  output  1/ADDR_W/1/1  registered control.
- stall_count  output  16  saturating count of load-use bubbles.

Behaviour:
- Reset (asynchronous, reset_n=0): opnd_a, opnd_b, ex_rd and stall_count are 0; ex_valid, ex_writes_reg and ex_is_load are 0.
- Operand A resolution, combinational, first match wins:
  1. EX: ex_fwd_valid & ex_fwd_we & !ex_fwd_is_load & ex_fwd_rd==id_rs → ex_fwd_data.
  2. MEM: mem_fwd_valid & mem_fwd_we & rd match → mem_fwd_data.
  3. WB: wb_write & wb_addr match → wb_data. Covers the register file's same-edge write not yet being visible on read.
  4. Otherwise rf_data1.
- Operand B: identical resolution on id_rt, falling back to rf_data2.
- Load-use: load_use = id_valid & ex_fwd_valid & ex_fwd_is_load & ex_fwd_we & ((id_uses_rs & ex_fwd_rd==id_rs) | (id_uses_rt & ex_fwd_rd==id_rt)).
- stall = !flush & (load_use | ex_hold).
- Register update, per rising edge, first match wins:
  1. flush=1 → ex_valid←0, ex_writes_reg←0, ex_is_load←0. Operands are don't-care. Flush overrides ex_hold.
  2. ex_hold=1 → all ID/EX registers keep their values.
  3. load_use=1 → bubble: ex_valid←0, ex_writes_reg←0, ex_is_load←0; stall_count increments, saturating at 0xFFFF.
  4. Otherwise: load opnd_a and opnd_b with the resolved values, ex_valid←id_valid, ex_writes_reg←id_writes_reg & id_valid, ex_is_load←id_is_load & id_valid, ex_rd←id_rd.
- Latency: one cycle from ID inputs to the ex_* and opnd_* outputs. A load-use hazard costs exactly one bubble: the next cycle the load is in MEM and forwards from there.
- Unused sources (id_uses_*=0) never cause a stall, but operands are still resolved.
- Register 0 is a normal register with no hardwired zero, so forwarding applies to it.
- Invalid ID slot (id_valid=0): no stall; a bubble propagates.

Test Plan:
- Reset mid-run: assert reset_n=0 asynchronously between edges → all outputs 0 immediately, stall_count=0.
- EX priority: EX writes r1=0x1111, MEM writes r1=0x2222, WB writes r1=0x3333, ID reads rs=r1 → opnd_a=0x1111 next edge. With EX not matching → 0x2222. With only WB matching → 0x3333. With nothing matching → rf_data1.
- Load-use: EX load to r2, ID uses rt=r2 → stall=1 for one cycle, bubble (ex_valid=0), stall_count=1. Next cycle MEM forwards 0xBEEF → opnd_b=0xBEEF, ex_valid=1.
- Load with unused source: EX load to r2, ID has id_uses_rt=0 and rt=r2 → stall=0, no bubble.
- Flush vs stall: load_use and flush together → stall=0, ex_valid=0 next edge, stall_count unchanged. Flush together with ex_hold → ex_valid cleared.
- Hold: ex_hold=1 for 3 cycles with opnd_a=0x00A5 latched → outputs stable, stall=1. On release the new ID instruction latches.
